// File: rtl/cmd_pkg.sv
// Shared types and constants for the UART/button command scheduler.
package cmd_pkg;

  // Stopwatch state encoding: STOP=0, RUN=1, CLEAR=2
  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CLEAR = 2'd2
  } sw_state_e;

  // Internal command selected for the current cycle
  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_RUN  = 3'd1,
    CMD_CLR  = 3'd2,
    CMD_SEC  = 3'd3,
    CMD_MIN  = 3'd4,
    CMD_HOUR = 3'd5,
    CMD_SPEC = 3'd6
  } cmd_e;

  // Lower-case ASCII command letters; upper case differs only in bit 5
  localparam logic [7:0] ASC_RUN  = 8'h72; // 'r'
  localparam logic [7:0] ASC_CLR  = 8'h63; // 'c'
  localparam logic [7:0] ASC_SEC  = 8'h73; // 's'
  localparam logic [7:0] ASC_MIN  = 8'h6D; // 'm'
  localparam logic [7:0] ASC_HOUR = 8'h68; // 'h'
  localparam logic [7:0] ASC_SPEC = 8'h69; // 'i'

  // Case-insensitive decode: forcing bit 5 high folds 'A'-'Z' onto 'a'-'z'.
  // Non-letters that fold onto a command letter cannot exist, since only
  // 0x52/0x72 etc. map onto the command codes.
  function automatic cmd_e decode_byte(input logic [7:0] b);
    logic [7:0] lc;
    lc = b | 8'h20;
    case (lc)
      ASC_RUN:  decode_byte = CMD_RUN;
      ASC_CLR:  decode_byte = CMD_CLR;
      ASC_SEC:  decode_byte = CMD_SEC;
      ASC_MIN:  decode_byte = CMD_MIN;
      ASC_HOUR: decode_byte = CMD_HOUR;
      ASC_SPEC: decode_byte = CMD_SPEC;
      default:  decode_byte = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Small synchronous FIFO with combinational read data at the head.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [AW:0]             count;
  logic                    do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  // A push into a full FIFO is still accepted when the head leaves the same cycle
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage write; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_sched.sv
// Arbitrates UART command bytes against buttons, runs the stopwatch FSM,
// gates clock-adjust pulses by mode and echoes processed UART bytes.
module uart_cmd_sched
  import cmd_pkg::*;
#(
  parameter int         FIFO_DEPTH = 4,
  parameter bit         ECHO_EN    = 1'b1,
  parameter logic [7:0] ERR_CHAR   = 8'h3F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_hour,
  input  logic       sw_mode,
  input  logic       tx_busy,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       clk_sec_inc,
  output logic       clk_min_inc,
  output logic       clk_hour_inc,
  output logic       special,
  output logic [7:0] tx_data,
  output logic       tx_start,
  output logic       rx_overflow
);
  sw_state_e  state, state_nxt;
  cmd_e       cmd, rx_cmd;
  logic [7:0] fifo_head, echo_data;
  logic       fifo_full, fifo_empty, pop, any_btn, echo_valid;

  assign any_btn = btn_run | btn_clear | btn_sec | btn_min | btn_hour;
  // Buttons own the cycle; a pending echo stalls the queue so bytes are
  // echoed strictly one at a time
  assign pop     = ~fifo_empty & ~any_btn & (~echo_valid | ~ECHO_EN);
  assign rx_cmd  = decode_byte(fifo_head);

  cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_done),
    .wdata (rx_data),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Pick this cycle's command: buttons by fixed priority, else the popped byte
  always_comb begin
    cmd = CMD_NONE;
    if      (btn_clear) cmd = CMD_CLR;
    else if (btn_run)   cmd = CMD_RUN;
    else if (btn_hour)  cmd = CMD_HOUR;
    else if (btn_min)   cmd = CMD_MIN;
    else if (btn_sec)   cmd = CMD_SEC;
    else if (pop)       cmd = rx_cmd;
  end

  // Stopwatch state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_STOP;
    else     state <= state_nxt;
  end

  // Stopwatch next state; CLEAR lasts one cycle unless a run arrives
  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: begin
        if      (cmd == CMD_RUN) state_nxt = ST_RUN;
        else if (cmd == CMD_CLR) state_nxt = ST_CLEAR;
      end
      ST_RUN:   if (cmd == CMD_RUN) state_nxt = ST_STOP;
      ST_CLEAR: state_nxt = (cmd == CMD_RUN) ? ST_RUN : ST_STOP;
      default:  state_nxt = ST_STOP;
    endcase
  end

  assign sw_run   = (state == ST_RUN);
  assign sw_clear = (state == ST_CLEAR);

  // Registered one-cycle adjust/special pulses; adjusts only in clock mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sec_inc  <= 1'b0;
      clk_min_inc  <= 1'b0;
      clk_hour_inc <= 1'b0;
      special      <= 1'b0;
    end else begin
      clk_sec_inc  <= sw_mode & (cmd == CMD_SEC);
      clk_min_inc  <= sw_mode & (cmd == CMD_MIN);
      clk_hour_inc <= sw_mode & (cmd == CMD_HOUR);
      special      <= (cmd == CMD_SPEC);
    end
  end

  // Sticky overflow: byte lost only when full and nothing leaves this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              rx_overflow <= 1'b0;
    else if (rx_done & fifo_full & ~pop)  rx_overflow <= 1'b1;
  end

  assign tx_start = echo_valid & ~tx_busy;
  assign tx_data  = echo_data;

  // Echo holding register: loads on pop, empties when the TX accepts it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_valid <= 1'b0;
      echo_data  <= 8'h00;
    end else if (ECHO_EN && pop) begin
      echo_valid <= 1'b1;
      echo_data  <= (rx_cmd == CMD_NONE) ? ERR_CHAR : fifo_head;
    end else if (tx_start) begin
      echo_valid <= 1'b0;
    end
  end

endmodule
